// File: rtl/fast_vram_sched.sv
// fast_vram_sched
// Slot scheduler / arbiter for the fast (upper 2K-word) sprite VRAM.
// A 16-cycle frame is split into four 4-cycle slots:
//   slot 0 : Y-parse read (idle when PARSE_EN=0)
//   slot 1 : active-list write (ACTIVE_WR_REQ=1) or read
//   slot 2 : render read
//   slot 3 : buffered CPU access (idle when nothing pending)
// Optional feature macro: FAST_VRAM_CPU_STEAL_EN. When defined, an idle
// slot 0 (PARSE_EN=0) is given to a pending CPU access.
//
// Ports
//   CLK_24M        in   system clock
//   nRESET         in   synchronous active-low reset
//   SYNC           in   frame realign pulse (next cnt = 0, aborts slot)
//   PARSE_EN/ADDR  in   Y-parse request and address
//   ACTIVE_*       in   active-list write request, address, write data
//   RENDER_ADDR    in   render read address
//   CPU_REQ/WR/ADDR/WDATA in  CPU request (held until CPU_ACK)
//   VRAM_DIN       in   VRAM read bus
//   CPU_ACK        out  one-cycle CPU completion pulse
//   CPU_RDATA      out  CPU read data, held after CPU_ACK
//   ACTIVE_ACK     out  one-cycle active-list write completion pulse
//   LATCH          out  one-hot read strobes [parse, active, render, cpu]
//   SLOT           out  current slot number
//   VRAM_ADDR/DOUT/OE out registered VRAM address, write data, bus drive
//   nCWE           out  VRAM write enable, active low
//
// Frame position table (cnt = {slot, phase})
//   phase | meaning
//   0     | owner/address launched (decided on the edge entering it)
//   1     | write strobe low for write slots
//   2     | write strobe low for write slots
//   3     | read strobe (LATCH); data sampled on the edge ending it
module fast_vram_sched (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        SYNC,
    input  logic        PARSE_EN,
    input  logic [10:0] PARSE_ADDR,
    input  logic        ACTIVE_WR_REQ,
    input  logic [10:0] ACTIVE_ADDR,
    input  logic [15:0] ACTIVE_WDATA,
    input  logic [10:0] RENDER_ADDR,
    input  logic        CPU_REQ,
    input  logic        CPU_WR,
    input  logic [10:0] CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    input  logic [15:0] VRAM_DIN,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    output logic        ACTIVE_ACK,
    output logic [3:0]  LATCH,
    output logic [1:0]  SLOT,
    output logic [10:0] VRAM_ADDR,
    output logic [15:0] VRAM_DOUT,
    output logic        VRAM_OE,
    output logic        nCWE
);

    localparam logic [1:0] OWN_PARSE  = 2'd0;
    localparam logic [1:0] OWN_ACTIVE = 2'd1;
    localparam logic [1:0] OWN_RENDER = 2'd2;
    localparam logic [1:0] OWN_CPU    = 2'd3;

    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_cpu_wr;
    logic [10:0] r_cpu_addr;
    logic [15:0] r_cpu_wdata;
    logic        r_acc_vld;
    logic        r_acc_wr;
    logic [1:0]  r_own;
    logic [10:0] r_vram_addr;
    logic [15:0] r_vram_dout;
    logic        r_vram_oe;
    logic        r_ncwe;
    logic [3:0]  r_latch;
    logic        r_cpu_ack;
    logic        r_active_ack;
    logic [15:0] r_cpu_rdata;

    logic [3:0]  w_cnt_nxt;
    logic        w_decide;
    logic        w_done;
    logic        w_cpu_done;
    logic        w_busy_avail;
    logic        w_cpu_accept;
    logic        w_nx_vld;
    logic        w_nx_wr;
    logic [1:0]  w_nx_own;
    logic [10:0] w_nx_addr;
    logic [15:0] w_nx_dout;
    logic        w_vld_post;
    logic        w_wr_post;
    logic [1:0]  w_own_post;
    logic [1:0]  w_ph_post;
    logic        w_ncwe_nxt;
    logic [3:0]  w_latch_nxt;

    // State register
    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            r_cnt        <= 4'd0;
            r_busy       <= 1'b0;
            r_cpu_wr     <= 1'b0;
            r_cpu_addr   <= 11'd0;
            r_cpu_wdata  <= 16'd0;
            r_acc_vld    <= 1'b0;
            r_acc_wr     <= 1'b0;
            r_own        <= OWN_PARSE;
            r_vram_addr  <= 11'd0;
            r_vram_dout  <= 16'd0;
            r_vram_oe    <= 1'b0;
            r_ncwe       <= 1'b1;
            r_latch      <= 4'd0;
            r_cpu_ack    <= 1'b0;
            r_active_ack <= 1'b0;
            r_cpu_rdata  <= 16'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_decide) begin
                r_acc_vld   <= w_nx_vld;
                r_acc_wr    <= w_nx_wr;
                r_own       <= w_nx_own;
                r_vram_addr <= w_nx_addr;
                r_vram_dout <= w_nx_dout;
                r_vram_oe   <= w_nx_vld & w_nx_wr;
            end
            r_ncwe       <= w_ncwe_nxt;
            r_latch      <= w_latch_nxt;
            r_cpu_ack    <= w_cpu_done;
            r_active_ack <= w_done && (r_own == OWN_ACTIVE) && r_acc_wr;
            if (w_cpu_done && !r_acc_wr) begin
                r_cpu_rdata <= VRAM_DIN;
            end
            if (w_cpu_done) begin
                r_busy <= 1'b0;
            end else if (w_cpu_accept) begin
                r_busy      <= 1'b1;
                r_cpu_wr    <= CPU_WR;
                r_cpu_addr  <= CPU_ADDR;
                r_cpu_wdata <= CPU_WDATA;
            end
        end
    end

    // Next-state: frame counter, slot completion and owner decision
    always_comb begin
        w_cnt_nxt    = SYNC ? 4'd0 : r_cnt + 4'd1;
        w_decide     = (w_cnt_nxt[1:0] == 2'd0);
        // A slot only completes if it reaches the end of phase 3; SYNC
        // earlier in the slot discards it without strobes or ACK.
        w_done       = r_acc_vld && (r_cnt[1:0] == 2'd3);
        w_cpu_done   = w_done && (r_own == OWN_CPU);
        // An access finishing on this edge must not be granted again.
        w_busy_avail = r_busy && !w_cpu_done;
        w_cpu_accept = CPU_REQ && !r_busy && !r_cpu_ack;

        w_nx_vld  = 1'b0;
        w_nx_wr   = 1'b0;
        w_nx_own  = OWN_PARSE;
        w_nx_addr = r_vram_addr;
        w_nx_dout = r_vram_dout;
        case (w_cnt_nxt[3:2])
            2'd0: begin
                if (PARSE_EN) begin
                    w_nx_vld  = 1'b1;
                    w_nx_own  = OWN_PARSE;
                    w_nx_addr = PARSE_ADDR;
                end
`ifdef FAST_VRAM_CPU_STEAL_EN
                else if (w_busy_avail) begin
                    w_nx_vld  = 1'b1;
                    w_nx_wr   = r_cpu_wr;
                    w_nx_own  = OWN_CPU;
                    w_nx_addr = r_cpu_addr;
                    if (r_cpu_wr) begin
                        w_nx_dout = r_cpu_wdata;
                    end
                end
`endif
            end
            2'd1: begin
                w_nx_vld  = 1'b1;
                w_nx_wr   = ACTIVE_WR_REQ;
                w_nx_own  = OWN_ACTIVE;
                w_nx_addr = ACTIVE_ADDR;
                if (ACTIVE_WR_REQ) begin
                    w_nx_dout = ACTIVE_WDATA;
                end
            end
            2'd2: begin
                w_nx_vld  = 1'b1;
                w_nx_own  = OWN_RENDER;
                w_nx_addr = RENDER_ADDR;
            end
            default: begin
                if (w_busy_avail) begin
                    w_nx_vld  = 1'b1;
                    w_nx_wr   = r_cpu_wr;
                    w_nx_own  = OWN_CPU;
                    w_nx_addr = r_cpu_addr;
                    if (r_cpu_wr) begin
                        w_nx_dout = r_cpu_wdata;
                    end
                end
            end
        endcase
    end

    // Output strobes, registered from the post-edge slot state
    always_comb begin
        w_vld_post  = w_decide ? w_nx_vld : r_acc_vld;
        w_wr_post   = w_decide ? w_nx_wr  : r_acc_wr;
        w_own_post  = w_decide ? w_nx_own : r_own;
        w_ph_post   = w_cnt_nxt[1:0];
        w_ncwe_nxt  = !(w_vld_post && w_wr_post &&
                        ((w_ph_post == 2'd1) || (w_ph_post == 2'd2)));
        w_latch_nxt = 4'd0;
        if (w_vld_post && !w_wr_post && (w_ph_post == 2'd3)) begin
            w_latch_nxt = 4'b0001 << w_own_post;
        end
    end

    assign SLOT       = r_cnt[3:2];
    assign VRAM_ADDR  = r_vram_addr;
    assign VRAM_DOUT  = r_vram_dout;
    assign VRAM_OE    = r_vram_oe;
    assign nCWE       = r_ncwe;
    assign LATCH      = r_latch;
    assign CPU_ACK    = r_cpu_ack;
    assign ACTIVE_ACK = r_active_ack;
    assign CPU_RDATA  = r_cpu_rdata;

endmodule

// File: doc/fast_vram_sched.md
# fast_vram_sched

Slot scheduler and arbiter for the fast (upper 2K-word) sprite VRAM. It divides each 16-cycle CLK_24M frame, aligned to the 1.5 MHz pixel-pair clock, into four fixed 4-cycle access slots. The slots go to Y-parse reads, active-list read/write, render reads and one buffered CPU access. It drives the VRAM address, data, output-enable and write-strobe, and gives each client a one-cycle latch strobe so it can sample the read bus.

## Interface
Parameters: none.

Ports:
- CLK_24M  in  1  system clock; sole clock.
- nRESET  in  1  synchronous, active-low reset.
- SYNC  in  1  frame realign pulse, derived from the LSPC_1_5M edge.
- PARSE_EN  in  1  Y-parse phase active.
- PARSE_ADDR  in  11  parse read address.
- ACTIVE_WR_REQ  in  1  active-list write wanted this frame.
- ACTIVE_ADDR  in  11  active-list read/write address.
- ACTIVE_WDATA  in  16  active-list write data.
- RENDER_ADDR  in  11  render Y/shrink read address.
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK.
- CPU_WR  in  1  1 = write, 0 = read.
- CPU_ADDR  in  11  CPU word address.
- CPU_WDATA  in  16  CPU write data.
- VRAM_DIN  in  16  VRAM read bus.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  16  CPU read data; valid while CPU_ACK=1, held afterwards.
- ACTIVE_ACK  out  1  one-cycle pulse when an active-list write completes.
- LATCH  out  4  one-hot read strobes: [0] parse, [1] active, [2] render, [3] CPU.
- SLOT  out  2  current slot number.
- VRAM_ADDR  out  11  VRAM address.
- VRAM_DOUT  out  16  VRAM write data.
- VRAM_OE  out  1  1 = drive VRAM_DOUT onto the bus.
- nCWE  out  1  VRAM write enable, active low.

## Operation
- A 4-bit frame counter cnt increments every cycle and wraps 15→0. SLOT=cnt[3:2]; phase=cnt[1:0].
- SYNC=1 loads cnt=0 on the next edge. SYNC overrides the increment.
- Slot owner and access type are decided on the edge entering phase 0, then frozen for 4 cycles.
- Slot 0: if PARSE_EN=1, read PARSE_ADDR. Otherwise the slot is idle.
- Slot 1: if ACTIVE_WR_REQ=1, write ACTIVE_WDATA to ACTIVE_ADDR. Otherwise read ACTIVE_ADDR.
- Slot 2: read RENDER_ADDR, unconditionally.
- Slot 3: serves the CPU if a request is pending (busy=1). Otherwise the slot is idle.
- CPU holding register:
  - It captures CPU_ADDR, CPU_WDATA and CPU_WR and sets busy on the edge where CPU_REQ=1, busy=0 and CPU_ACK=0.
  - busy clears on the edge that raises CPU_ACK.
  - CPU_REQ is ignored while busy=1.
- Idle slot: VRAM_ADDR holds its previous value, VRAM_OE=0, nCWE=1, no LATCH strobe.

## Timing
- VRAM_ADDR, VRAM_DOUT and VRAM_OE are registered. They update on the edge entering phase 0 and hold through phase 3.
- Write slot:
  - VRAM_OE=1 during phases 0–3.
  - nCWE=0 during phases 1–2 only.
  - ACTIVE_ACK or CPU_ACK pulses during the following cycle (phase 0 of the next slot).
- Read slot:
  - LATCH[n]=1 during phase 3.
  - Clients sample VRAM_DIN on the edge ending phase 3.
  - CPU_RDATA captures on that same edge; CPU_ACK=1 in the next cycle.
- CPU latency:
  - A request accepted before the edge entering slot 3 is served in that slot.
  - A request accepted on that edge, or later, waits for the next frame.
  - Worst case from acceptance to CPU_ACK: 20 cycles.
- SYNC mid-slot: the current access is aborted.
  - nCWE=1 on the next edge; no LATCH or ACK is issued for the aborted slot.
  - A pending CPU access stays busy and is served at the next slot 3.
- Reset values (also applied when reset is asserted mid-operation):
  - cnt=0, busy=0.
  - VRAM_ADDR=0, VRAM_DOUT=0, VRAM_OE=0, nCWE=1.
  - LATCH=0, CPU_ACK=0, ACTIVE_ACK=0, CPU_RDATA=0, SLOT=0.
  - A pending CPU access is discarded without ACK.

## Configuration
- FAST_VRAM_CPU_STEAL_EN defined: when PARSE_EN=0 and busy=1 at the slot-0 decision edge, slot 0 serves the CPU with the same timing as slot 3. LATCH[3] strobes on reads, not LATCH[0].
- FAST_VRAM_CPU_STEAL_EN undefined: slot 0 is idle whenever PARSE_EN=0.

## Test plan
- Reset, then free-run with no requests and PARSE_EN=0, ACTIVE_WR_REQ=0 → SLOT sequence 0,0,0,0,1,1,1,1,2…; LATCH=0010 at cnt=7 and 0100 at cnt=11; nCWE is never 0.
- CPU write (addr 0x7FF, data 0xA5C3) accepted at cnt=2 → VRAM_ADDR=0x7FF and VRAM_DOUT=0xA5C3 at cnt=12–15; nCWE=0 at cnt=13–14; CPU_ACK=1 at cnt=0 of the next frame.
- CPU read of 0x123 with VRAM_DIN=0xBEEF during slot 3 → LATCH[3]=1 at cnt=15; CPU_RDATA=0xBEEF with CPU_ACK pulse; a second CPU_REQ during busy is ignored.
- ACTIVE_WR_REQ=1, ACTIVE_ADDR=0x600, ACTIVE_WDATA=0x0042 → write in slot 1 with nCWE=0 at cnt=5–6; ACTIVE_ACK=1 at cnt=8; LATCH[1]=0.
- SYNC asserted at cnt=13 during a CPU write → nCWE=1 next cycle, cnt=0, no CPU_ACK; the write completes in the following slot 3.
- With FAST_VRAM_CPU_STEAL_EN defined, PARSE_EN=0 and a CPU read pending at cnt=15 → served in slot 0 (cnt=0–3), LATCH[3] at cnt=3, CPU_ACK at cnt=4; without the macro, CPU_ACK arrives at cnt=0 of the following frame.
